mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 20: address width of both requester ports and the memory port.
REQ-002 Parameter LATENCY, default 10: latency of the downstream memory; used only for documentation and bench timing, not in the logic.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 i_req  input  1  instruction-fetch read request (read-only port); level, held until i_resp_valid.
REQ-006 i_addr  input  ADDR_WIDTH  fetch address.
REQ-007 i_rdata  output  32  fetch read data; valid when i_resp_valid=1.
REQ-008 i_resp_valid  output  1  one-cycle completion pulse for the fetch port.
REQ-009 d_req  input  1  data-port request; level, held until d_resp_valid.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  ADDR_WIDTH  data address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_rdata  output  32  load data; valid when d_resp_valid=1 and the operation was a read.
REQ-014 d_resp_valid  output  1  one-cycle completion pulse for the data port (reads and writes).
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 mem_cs, mem_re, mem_wr  output  1 each  memory chip-select, read strobe, write strobe.
REQ-017 mem_address  output  ADDR_WIDTH  latched request address.
REQ-018 mem_data_in  output  32  latched store data.
REQ-019 mem_data_out  input  32  memory read data.
REQ-020 mem_done  input  1  memory completion flag; level, cleared by the memory when it accepts a new request.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs are registered.
REQ-022 IDLE: with any request pending, grant one port, latch port id, address, we (forced 0 for the I port), and wdata, then go to ISSUE; with no request pending, stay in IDLE.
REQ-023 Arbitration: a lone requester wins; with i_req and d_req both high, the port not granted last wins (round-robin); last_grant updates on every grant.
REQ-024 ISSUE: mem_cs=1 for exactly one cycle, with mem_re=!we and mem_wr=we; then go to WAIT.
REQ-025 mem_cs, mem_re and mem_wr are 0 in every state except ISSUE; mem_address and mem_data_in hold their latched values until the next grant.
REQ-026 WAIT: sample mem_done; on mem_done=1, capture mem_data_out into the granted port's rdata for a read (rdata unchanged for a write), then go to RESP; otherwise stay in WAIT with no timeout.
REQ-027 RESP: the granted port's resp_valid=1 for exactly one cycle; then go to IDLE.
REQ-028 i_rdata and d_rdata hold their values between responses.
REQ-029 Requests arriving outside IDLE are not sampled; requester inputs may change after the grant cycle without effect.
REQ-030 A req still high in the cycle after its resp_valid is treated as a new request.
REQ-031 Latency with the companion memory: req sampled in IDLE at cycle 0 -> resp_valid in cycle LATENCY+4.
REQ-032 At most one outstanding memory operation; the two resp_valid outputs are never high together.

Reset
REQ-033 On rst, asynchronously: state=IDLE, last_grant=I (so D wins the first conflict), and all outputs including rdata and address/data latches = 0.
REQ-034 Reset mid-operation abandons the transaction, with no resp_valid pulse; the memory shares rst.

Verification
REQ-035 Single fetch: mem[0x100]=0xAB, i_req with i_addr=0x100 at cycle 0 (LATENCY=10) -> mem_cs/mem_re high in cycle 1 only; i_resp_valid high in cycle 14 only, with i_rdata=0xAB.
REQ-036 Store then load: d_we=1, d_addr=0x20, d_wdata=0x5A -> d_resp_valid pulses with d_rdata unchanged; then a read of 0x20 -> d_rdata=0x5A.
REQ-037 Simultaneous requests after reset, both held high -> D granted first, then I, then D (round-robin); never two outstanding.
REQ-038 Requester input churn: change i_addr one cycle after the grant -> mem_address keeps the originally latched address throughout.
REQ-039 Reset asserted during WAIT -> all outputs 0 immediately; no resp_valid; the next request completes normally in LATENCY+4 cycles.
REQ-040 Back-to-back fetch, req held high -> second grant in the cycle after RESP; busy low for exactly that one IDLE cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported memory between an instruction-fetch port (read
// only) and a data port (read/write). One memory operation is in flight at a
// time. A four-state FSM (IDLE -> ISSUE -> WAIT -> RESP) sequences each
// transaction, and every output is driven from a register.
//
// Ports
//   clk, rst          single clock; asynchronous active-high reset
//   i_req, i_addr     fetch request (level, held until i_resp_valid)
//   i_rdata           fetch read data, valid with i_resp_valid
//   i_resp_valid      one-cycle fetch completion pulse
//   d_req, d_we       data request (level) and write enable
//   d_addr, d_wdata   data address and store data
//   d_rdata           load data, valid with d_resp_valid on a read
//   d_resp_valid      one-cycle data completion pulse (reads and writes)
//   busy              high whenever the FSM is not in IDLE
//   mem_cs/re/wr      memory chip-select, read strobe, write strobe
//   mem_address       latched request address
//   mem_data_in       latched store data
//   mem_data_out      memory read data
//   mem_done          memory completion flag (level)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int LATENCY    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [31:0]           i_rdata,
    output logic                  i_resp_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic [31:0]           d_rdata,
    output logic                  d_resp_valid,
    output logic                  busy,
    output logic                  mem_cs,
    output logic                  mem_re,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_data_in,
    input  logic [31:0]           mem_data_out,
    input  logic                  mem_done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic last_grant_d;
    logic grant_d;
    logic lat_we;
    logic grant_now;
    logic pick_d;
    logic issue_we;

    // LATENCY only describes the companion memory; the control logic waits on
    // mem_done instead of counting, so the value never reaches any logic.
    if (LATENCY < 1) begin : g_latency_informational
    end

    // Arbitration and next-state decode. When both ports request, the port
    // that was not granted last wins; a lone requester always wins.
    always_comb begin
        next_state = state;
        pick_d     = d_req && (!i_req || !last_grant_d);
        grant_now  = 1'b0;
        issue_we   = pick_d && d_we;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_now  = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (mem_done) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant bookkeeping and request latches. These only change on a grant, so
    // requester inputs that move afterwards cannot disturb the transaction.
    // The fetch port never writes, so its latched write enable is forced low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_d <= 1'b0;
            grant_d      <= 1'b0;
            lat_we       <= 1'b0;
            mem_address  <= '0;
            mem_data_in  <= '0;
        end else if (grant_now) begin
            last_grant_d <= pick_d;
            grant_d      <= pick_d;
            lat_we       <= issue_we;
            mem_address  <= pick_d ? d_addr : i_addr;
            mem_data_in  <= d_wdata;
        end
    end

    // Strobes, busy and response pulses are registered from the next state so
    // that they line up exactly with the state they belong to. ISSUE is only
    // reachable from IDLE, so its read/write strobes use the value being
    // latched on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            mem_cs       <= 1'b0;
            mem_re       <= 1'b0;
            mem_wr       <= 1'b0;
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;
        end else begin
            busy         <= (next_state != IDLE);
            mem_cs       <= (next_state == ISSUE);
            mem_re       <= (next_state == ISSUE) && !issue_we;
            mem_wr       <= (next_state == ISSUE) && issue_we;
            i_resp_valid <= (next_state == RESP) && !grant_d;
            d_resp_valid <= (next_state == RESP) && grant_d;
        end
    end

    // Read data is captured once, on the edge that leaves WAIT, into the
    // granted port only; writes leave both rdata registers untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if ((state == WAIT) && mem_done && !lat_we) begin
            if (grant_d) begin
                d_rdata <= mem_data_out;
            end else begin
                i_rdata <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A companion memory model answers the
// arbiter's strobes. A transaction-level reference model predicts, for every
// cycle, which port is granted, when the strobe and response pulses appear
// (grant + 1 and grant + LATENCY + 4) and what read data is returned, using a
// shadow copy of memory contents. Directed scenarios are followed by a
// randomized phase with two independent requesters.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_WIDTH = 20;
    localparam int LATENCY    = 10;
    localparam int RESP_DELAY = LATENCY + 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  i_req = 1'b0;
    logic [ADDR_WIDTH-1:0] i_addr = '0;
    logic [31:0]           i_rdata;
    logic                  i_resp_valid;
    logic                  d_req = 1'b0;
    logic                  d_we = 1'b0;
    logic [ADDR_WIDTH-1:0] d_addr = '0;
    logic [31:0]           d_wdata = '0;
    logic [31:0]           d_rdata;
    logic                  d_resp_valid;
    logic                  busy;
    logic                  mem_cs;
    logic                  mem_re;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data_in;
    logic [31:0]           mem_data_out;
    logic                  mem_done;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    mem_arbiter #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LATENCY   (LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_resp_valid(i_resp_valid),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp_valid(d_resp_valid),
        .busy        (busy),
        .mem_cs      (mem_cs),
        .mem_re      (mem_re),
        .mem_wr      (mem_wr),
        .mem_address (mem_address),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out),
        .mem_done    (mem_done)
    );

    always #5 clk = ~clk;

    // Initial memory contents; location 0x100 holds 0xAB for the fetch test.
    function automatic logic [31:0] initWord(input logic [11:0] a);
        if (a == 12'h100) begin
            return 32'h0000_00AB;
        end
        return ({20'h0, a} * 32'h0100_0193) ^ 32'hC0DE_0000;
    endfunction

    // Companion memory: accepts on mem_cs, raises mem_done LATENCY + 1 cycles
    // after the accepting cycle, and clears mem_done on the next accept.
    logic [31:0] mem_store [0:4095];
    bit   [4095:0] mem_written = '0;
    logic [31:0] mem_rd_q;
    int          mem_cnt;
    logic        mem_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_done <= 1'b0;
            mem_pend <= 1'b0;
            mem_cnt  <= 0;
            mem_rd_q <= '0;
        end else if (mem_cs) begin
            mem_done <= 1'b0;
            mem_pend <= 1'b1;
            mem_cnt  <= LATENCY;
            if (mem_wr) begin
                mem_store[mem_address[11:0]]   <= mem_data_in;
                mem_written[mem_address[11:0]] <= 1'b1;
            end else begin
                mem_rd_q <= mem_written[mem_address[11:0]] ? mem_store[mem_address[11:0]]
                                                           : initWord(mem_address[11:0]);
            end
        end else if (mem_pend) begin
            if (mem_cnt == 0) begin
                mem_done <= 1'b1;
                mem_pend <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
    end

    assign mem_data_out = mem_rd_q;

    // Reference model state
    bit                    m_busy;
    bit                    m_port_d;
    bit                    m_last_d;
    int                    m_grant;
    int                    m_resp;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  m_we;
    logic [31:0]           m_wdata;
    logic [31:0]           m_rd_val;
    logic [31:0]           m_i_rdata;
    logic [31:0]           m_d_rdata;
    logic [31:0]           shadow [0:4095];
    bit   [4095:0]         shadow_written = '0;

    // Observation logs used by the directed scenarios
    bit i_resp_seen;
    bit d_resp_seen;
    int cs_cycles[$];
    int resp_cycles[$];
    bit resp_order[$];
    int idle_log[$];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    task automatic modelReset();
        m_busy      = 1'b0;
        m_port_d    = 1'b0;
        m_last_d    = 1'b0;
        m_grant     = 0;
        m_resp      = 0;
        m_addr      = '0;
        m_we        = 1'b0;
        m_wdata     = '0;
        m_rd_val    = '0;
        m_i_rdata   = '0;
        m_d_rdata   = '0;
        i_resp_seen = 1'b0;
        d_resp_seen = 1'b0;
        cycle       = 0;
    endtask

    // Compare every output against the model for the current cycle, log
    // observations, then advance the model across the coming clock edge.
    task automatic checkCycle();
        bit exp_cs;
        bit exp_iv;
        bit exp_dv;
        if (m_busy && cycle == m_resp && !m_we) begin
            if (m_port_d) begin
                m_d_rdata = m_rd_val;
            end else begin
                m_i_rdata = m_rd_val;
            end
        end
        exp_cs = m_busy && (cycle == m_grant + 1);
        exp_iv = m_busy && (cycle == m_resp) && !m_port_d;
        exp_dv = m_busy && (cycle == m_resp) && m_port_d;

        checkOutput("busy",         64'(busy),         64'(m_busy));
        checkOutput("mem_cs",       64'(mem_cs),       64'(exp_cs));
        checkOutput("mem_re",       64'(mem_re),       64'(exp_cs && !m_we));
        checkOutput("mem_wr",       64'(mem_wr),       64'(exp_cs && m_we));
        checkOutput("mem_address",  64'(mem_address),  64'(m_addr));
        checkOutput("mem_data_in",  64'(mem_data_in),  64'(m_wdata));
        checkOutput("i_resp_valid", 64'(i_resp_valid), 64'(exp_iv));
        checkOutput("d_resp_valid", 64'(d_resp_valid), 64'(exp_dv));
        checkOutput("i_rdata",      64'(i_rdata),      64'(m_i_rdata));
        checkOutput("d_rdata",      64'(d_rdata),      64'(m_d_rdata));

        i_resp_seen = i_resp_valid;
        d_resp_seen = d_resp_valid;
        if (mem_cs) cs_cycles.push_back(cycle);
        if (!busy) idle_log.push_back(cycle);
        if (i_resp_valid) begin
            resp_cycles.push_back(cycle);
            resp_order.push_back(1'b0);
        end
        if (d_resp_valid) begin
            resp_cycles.push_back(cycle);
            resp_order.push_back(1'b1);
        end

        if (m_busy && cycle == m_resp) begin
            m_busy = 1'b0;
        end else if (!m_busy && (i_req || d_req)) begin
            m_port_d = d_req && (!i_req || !m_last_d);
            m_last_d = m_port_d;
            m_addr   = m_port_d ? d_addr : i_addr;
            m_we     = m_port_d && d_we;
            m_wdata  = d_wdata;
            m_grant  = cycle;
            m_resp   = cycle + RESP_DELAY;
            m_busy   = 1'b1;
            if (m_we) begin
                shadow[m_addr[11:0]]         = m_wdata;
                shadow_written[m_addr[11:0]] = 1'b1;
            end else begin
                m_rd_val = shadow_written[m_addr[11:0]] ? shadow[m_addr[11:0]] : initWord(m_addr[11:0]);
            end
        end
    endtask

    // One clock cycle: inputs are already driven; check at the falling edge,
    // then return just after the next rising edge for new stimulus.
    task automatic tick();
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic runUntilResp(input bit port_d, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (port_d ? d_resp_seen : i_resp_seen) begin
                at = cycle - 1;
                break;
            end
        end
    endtask

    task automatic doReset();
        rst    = 1'b1;
        i_req  = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        #1;
        checkOutput("rst_flags", 64'({busy, mem_cs, mem_re, mem_wr, i_resp_valid, d_resp_valid}), 64'(0));
        checkOutput("rst_mem_address", 64'(mem_address), 64'(0));
        checkOutput("rst_mem_data_in", 64'(mem_data_in), 64'(0));
        checkOutput("rst_i_rdata", 64'(i_rdata), 64'(0));
        checkOutput("rst_d_rdata", 64'(d_rdata), 64'(0));
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_no_resp", 64'({i_resp_valid, d_resp_valid}), 64'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    function automatic logic [ADDR_WIDTH-1:0] randAddr();
        return ADDR_WIDTH'($urandom_range(0, 31));
    endfunction

    // Randomized requesters: hold a request until its response, then either
    // drop it or keep it high as a fresh request; the granted port churns its
    // inputs while the transaction is in flight.
    task automatic applyStimulus();
        if (i_req && i_resp_seen) begin
            if ($urandom_range(0, 3) == 0) i_addr = randAddr();
            else i_req = 1'b0;
        end else if (i_req && m_busy && !m_port_d && cycle > m_grant) begin
            if ($urandom_range(0, 1) == 0) i_addr = randAddr();
        end else if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req  = 1'b1;
            i_addr = randAddr();
        end

        if (d_req && d_resp_seen) begin
            if ($urandom_range(0, 3) == 0) begin
                d_addr  = randAddr();
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
            end else begin
                d_req = 1'b0;
            end
        end else if (d_req && m_busy && m_port_d && cycle > m_grant) begin
            if ($urandom_range(0, 1) == 0) begin
                d_addr  = randAddr();
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
            end
        end else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req   = 1'b1;
            d_addr  = randAddr();
            d_we    = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int at;
        int start;
        int n;
        logic [2:0] ord;

        #2;
        doReset();

        // Single fetch of 0x100
        cs_cycles.delete();
        i_req  = 1'b1;
        i_addr = 20'h100;
        runUntilResp(1'b0, 40, at);
        i_req = 1'b0;
        checkOutput("fetch_resp_cycle", 64'(at), 64'(RESP_DELAY));
        checkOutput("fetch_rdata", 64'(i_rdata), 64'(32'hAB));
        checkOutput("fetch_cs_count", 64'(cs_cycles.size()), 64'(1));
        if (cs_cycles.size() >= 1) checkOutput("fetch_cs_cycle", 64'(cs_cycles[0]), 64'(1));

        // Store then load on the data port
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 20'h20;
        d_wdata = 32'h5A;
        start   = cycle;
        runUntilResp(1'b1, 40, at);
        d_req = 1'b0;
        d_we  = 1'b0;
        checkOutput("store_latency", 64'(at - start), 64'(RESP_DELAY));
        checkOutput("store_rdata_unchanged", 64'(d_rdata), 64'(0));
        tick();
        d_req  = 1'b1;
        d_addr = 20'h20;
        runUntilResp(1'b1, 40, at);
        d_req = 1'b0;
        checkOutput("load_rdata", 64'(d_rdata), 64'(32'h5A));

        // Requester churn after the grant
        i_req  = 1'b1;
        i_addr = 20'h7;
        tick();
        i_addr = 20'h155;
        tick();
        tick();
        checkOutput("churn_addr", 64'(mem_address), 64'(20'h7));
        i_addr = 20'h3;
        runUntilResp(1'b0, 40, at);
        i_req = 1'b0;
        checkOutput("churn_rdata", 64'(i_rdata), 64'(initWord(12'h7)));

        // Simultaneous requests after reset: D, I, D
        doReset();
        resp_order.delete();
        i_req  = 1'b1;
        i_addr = 20'h30;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 20'h40;
        for (int k = 0; k < 3 * (RESP_DELAY + 2) + 5; k++) begin
            tick();
            if (resp_order.size() >= 3) break;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        checkOutput("rr_resp_count", 64'(resp_order.size()), 64'(3));
        ord = '0;
        for (int k = 0; k < resp_order.size() && k < 3; k++) ord = {ord[1:0], resp_order[k]};
        checkOutput("rr_order", 64'(ord), 64'(3'b101));

        // Back-to-back fetch with the request held high
        tick();
        cs_cycles.delete();
        resp_cycles.delete();
        idle_log.delete();
        i_req  = 1'b1;
        i_addr = 20'h11;
        for (int k = 0; k < 2 * (RESP_DELAY + 2) + 5; k++) begin
            tick();
            if (resp_cycles.size() >= 2) break;
        end
        i_req = 1'b0;
        checkOutput("b2b_cs_count", 64'(cs_cycles.size()), 64'(2));
        if (cs_cycles.size() >= 2 && resp_cycles.size() >= 1) begin
            checkOutput("b2b_regrant", 64'(cs_cycles[1]), 64'(resp_cycles[0] + 2));
            n = 0;
            foreach (idle_log[k]) begin
                if (idle_log[k] > cs_cycles[0] && idle_log[k] < cs_cycles[1]) n++;
            end
            checkOutput("b2b_idle_cycles", 64'(n), 64'(1));
        end

        // Reset while waiting on the memory, then a clean fetch
        i_req  = 1'b1;
        i_addr = 20'h9;
        for (int k = 0; k < 6; k++) tick();
        checkOutput("pre_reset_busy", 64'(busy), 64'(1));
        doReset();
        i_req  = 1'b1;
        i_addr = 20'h100;
        runUntilResp(1'b0, 40, at);
        i_req = 1'b0;
        checkOutput("post_reset_latency", 64'(at), 64'(RESP_DELAY));
        checkOutput("post_reset_rdata", 64'(i_rdata), 64'(32'hAB));

        // Randomized traffic from both requesters
        for (int k = 0; k < 1500; k++) begin
            applyStimulus();
            tick();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        for (int k = 0; k < 2 * RESP_DELAY; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
